grf_wb_arbiter: RTL and testbench

Writeback stage that drives the single write port of the general register file.
- Registers the MEM-stage result (MEM/WB pipeline register).
- Performs load-data extraction and extension, and selects the write data.
- Arbitrates the write port between the pipeline instruction and the multiply/divide unit's late result, which is held in a one-entry buffer with a valid/ready handshake.
- Outputs feed the register file write inputs (write enable, address, data, PC) directly.

---
 rtl/mips_wb_pkg.sv | 21 ++
 rtl/wb_load_ext.sv | 37 +++
 rtl/grf_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared writeback-stage constants and the register-file write request type.
// Imported by the load extender and the writeback arbiter.
package mips_wb_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } wb_req_t;

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian load-data extraction and sign/zero extension.
// Unknown load types pass the whole word, as LW does.
module wb_load_ext
    import mips_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (load_type)
            LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext = {24'd0, byte_sel};
            LD_H:    ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext = {16'd0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Writeback stage: MEM/WB register, write-data select, and arbitration of the
// register-file write port against a one-entry multiply/divide result buffer.
// Optional WB_TRACE_EN prints every committed register write.
module grf_wb_arbiter
    import mips_wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_LINK_OFS = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_reg_write,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_wd_sel,
    input  logic [31:0] m_alu_res,
    input  logic [31:0] m_mem_rdata,
    input  logic [2:0]  m_load_type,
    input  logic [1:0]  m_addr_lo,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_wa,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    logic [31:0] load_ext;
    logic [31:0] m_wd;

    logic        wb_valid;
    logic        wb_reg_write;
    wb_req_t     wb_req;

    logic        buf_full;
    wb_req_t     buf_req;

    logic        pipe_elig;
    logic        drain;
    logic        md_accept;

    wb_load_ext u_load_ext (
        .rdata     (m_mem_rdata),
        .load_type (m_load_type),
        .addr_lo   (m_addr_lo),
        .ext       (load_ext)
    );

    always_comb begin
        m_wd = m_alu_res;
        case (m_wd_sel)
            WD_MEM:  m_wd = load_ext;
            WD_LINK: m_wd = m_pc + PC_LINK_OFS;
            default: m_wd = m_alu_res;
        endcase
    end

    // Bubbles still capture the fields; wb_valid alone decides eligibility.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_req       <= '{wa: 5'd0, wd: 32'd0, pc: RESET_PC};
        end else begin
            wb_valid     <= m_valid && !flush_i;
            wb_reg_write <= m_reg_write;
            wb_req       <= '{wa: m_wa, wd: m_wd, pc: m_pc};
        end
    end

    assign pipe_elig = wb_valid && wb_reg_write && (wb_req.wa != 5'd0);
    assign drain     = !reset && !pipe_elig && buf_full;
    assign md_ready  = !reset && (!buf_full || drain);
    assign md_accept = md_valid && md_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_req  <= '{wa: 5'd0, wd: 32'd0, pc: RESET_PC};
        end else if (md_accept) begin
            buf_full <= 1'b1;
            buf_req  <= '{wa: md_wa, wd: md_wd, pc: md_pc};
        end else if (drain) begin
            buf_full <= 1'b0;
        end
    end

    // Outputs are forced idle while reset is high so a pending buffer entry
    // can never be committed in the reset cycle.
    always_comb begin
        grf_we = 1'b0;
        grf_wa = 5'd0;
        grf_wd = 32'd0;
        grf_pc = RESET_PC;
        if (!reset) begin
            if (pipe_elig) begin
                grf_we = 1'b1;
                grf_wa = wb_req.wa;
                grf_wd = wb_req.wd;
                grf_pc = wb_req.pc;
            end else if (buf_full) begin
                grf_we = (buf_req.wa != 5'd0);
                grf_wa = buf_req.wa;
                grf_wd = buf_req.wd;
                grf_pc = buf_req.pc;
            end
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_we) begin
            $display("@%08h: $%02d <= %08h", grf_pc, grf_wa, grf_wd);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter: load extension, link data,
// write-port arbitration with the md buffer, and reset behaviour.
module tb_grf_wb_arbiter;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_reg_write;
    logic [4:0]  m_wa;
    logic [1:0]  m_wd_sel;
    logic [31:0] m_alu_res;
    logic [31:0] m_mem_rdata;
    logic [2:0]  m_load_type;
    logic [1:0]  m_addr_lo;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(
        .RESET_PC    (RST_PC),
        .PC_LINK_OFS (32'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_reg_write (m_reg_write),
        .m_wa        (m_wa),
        .m_wd_sel    (m_wd_sel),
        .m_alu_res   (m_alu_res),
        .m_mem_rdata (m_mem_rdata),
        .m_load_type (m_load_type),
        .m_addr_lo   (m_addr_lo),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_wa       (md_wa),
        .md_wd       (md_wd),
        .md_pc       (md_pc),
        .grf_we      (grf_we),
        .grf_wa      (grf_wa),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic rw, input logic [4:0] wa,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [2:0] lt,
                        input logic [1:0] lo, input logic [31:0] pc);
        m_valid     = v;
        m_reg_write = rw;
        m_wa        = wa;
        m_wd_sel    = sel;
        m_alu_res   = alu;
        m_mem_rdata = rd;
        m_load_type = lt;
        m_addr_lo   = lo;
        m_pc        = pc;
    endtask

    task automatic idle();
        pipe(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0, 32'd0);
    endtask

    task automatic md(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] pc);
        md_valid = v;
        md_wa    = wa;
        md_wd    = wd;
        md_pc    = pc;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] wa,
                             input logic [31:0] wd, input logic [31:0] pc);
        check({tag, "_we"}, {31'd0, grf_we}, 32'd1);
        check({tag, "_wa"}, {27'd0, grf_wa}, {27'd0, wa});
        check({tag, "_wd"}, grf_wd, wd);
        check({tag, "_pc"}, grf_pc, pc);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_we"}, {31'd0, grf_we}, 32'd0);
        check({tag, "_wa"}, {27'd0, grf_wa}, 32'd0);
        check({tag, "_wd"}, grf_wd, 32'd0);
        check({tag, "_pc"}, grf_pc, RST_PC);
    endtask

    initial begin
        reset   = 1'b1;
        flush_i = 1'b0;
        idle();
        md(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        expect_idle("rst");
        check("rst_ready", {31'd0, md_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, md_ready}, 32'd1);
        expect_idle("post_rst");

        // Load extension
        pipe(1, 1, 5'd8, 2'd1, 32'd0, 32'h80FF_1234, 3'd1, 2'd3, 32'h0000_1000);
        step();
        expect_wr("lb3", 5'd8, 32'hFFFF_FF80, 32'h0000_1000);
        pipe(1, 1, 5'd8, 2'd1, 32'd0, 32'h80FF_1234, 3'd2, 2'd3, 32'h0000_1004);
        step();
        expect_wr("lbu3", 5'd8, 32'h0000_0080, 32'h0000_1004);
        pipe(1, 1, 5'd9, 2'd1, 32'd0, 32'h8001_ABCD, 3'd4, 2'd2, 32'h0000_1008);
        step();
        expect_wr("lhu2", 5'd9, 32'h0000_8001, 32'h0000_1008);
        pipe(1, 1, 5'd9, 2'd1, 32'd0, 32'h8001_ABCD, 3'd3, 2'd0, 32'h0000_100C);
        step();
        expect_wr("lh0", 5'd9, 32'hFFFF_ABCD, 32'h0000_100C);
        pipe(1, 1, 5'd3, 2'd1, 32'd0, 32'h80FF_1234, 3'd1, 2'd1, 32'h0000_1010);
        step();
        check("lb1_wd", grf_wd, 32'h0000_0012);
        pipe(1, 1, 5'd3, 2'd1, 32'd0, 32'h80FF_1234, 3'd0, 2'd1, 32'h0000_1014);
        step();
        check("lw1_wd", grf_wd, 32'h80FF_1234);
        pipe(1, 1, 5'd3, 2'd1, 32'd0, 32'h80FF_1234, 3'd7, 2'd2, 32'h0000_1018);
        step();
        check("lt7_wd", grf_wd, 32'h80FF_1234);

        // Link and reserved select
        pipe(1, 1, 5'd31, 2'd2, 32'hDEAD_BEEF, 32'd0, 3'd0, 2'd0, 32'h0000_3000);
        step();
        expect_wr("link", 5'd31, 32'h0000_3008, 32'h0000_3000);
        pipe(1, 1, 5'd4, 2'd3, 32'h1357_9BDF, 32'hFFFF_FFFF, 3'd0, 2'd0, 32'h0000_3004);
        step();
        expect_wr("sel3", 5'd4, 32'h1357_9BDF, 32'h0000_3004);

        // Collision: pipeline wins, md drains next, second offer stalls
        pipe(1, 1, 5'd6, 2'd0, 32'h0000_0066, 32'd0, 3'd0, 2'd0, 32'h0000_2000);
        md(1, 5'd5, 32'h0000_0011, 32'h0000_0100);
        #1;
        check("col_rdy_n", {31'd0, md_ready}, 32'd1);
        step();
        expect_wr("col_n1", 5'd6, 32'h0000_0066, 32'h0000_2000);
        idle();
        md(1, 5'd7, 32'h0000_0022, 32'h0000_0104);
        #1;
        check("col_rdy_n1", {31'd0, md_ready}, 32'd0);
        step();
        expect_wr("col_n2", 5'd5, 32'h0000_0011, 32'h0000_0100);
        check("col_rdy_n2", {31'd0, md_ready}, 32'd1);
        step();
        md(0, 5'd0, 32'd0, 32'd0);
        #1;
        expect_wr("col_n3", 5'd7, 32'h0000_0022, 32'h0000_0104);
        step();
        expect_idle("col_n4");

        // Suppressed pipeline writes
        pipe(1, 1, 5'd0, 2'd0, 32'h0000_00AA, 32'd0, 3'd0, 2'd0, 32'h0000_4000);
        step();
        expect_idle("wa0");
        pipe(1, 1, 5'd2, 2'd0, 32'h0000_00BB, 32'd0, 3'd0, 2'd0, 32'h0000_4004);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        expect_idle("flush");
        pipe(1, 1, 5'd10, 2'd0, 32'h0000_0010, 32'd0, 3'd0, 2'd0, 32'h0000_4008);
        md(1, 5'd9, 32'h0000_0099, 32'h0000_0200);
        step();
        md(0, 5'd0, 32'd0, 32'd0);
        pipe(1, 1, 5'd0, 2'd0, 32'h0000_0000, 32'd0, 3'd0, 2'd0, 32'h0000_400C);
        expect_wr("pre_wa0", 5'd10, 32'h0000_0010, 32'h0000_4008);
        step();
        expect_wr("wa0_drain", 5'd9, 32'h0000_0099, 32'h0000_0200);
        idle();
        step();
        expect_idle("wa0_after");

        // md result to register 0 drains silently
        md(1, 5'd0, 32'h0000_0055, 32'h0000_0300);
        step();
        md(0, 5'd0, 32'd0, 32'd0);
        #1;
        check("md0_we", {31'd0, grf_we}, 32'd0);
        check("md0_wd", grf_wd, 32'h0000_0055);
        step();
        expect_idle("md0_after");

        // Reset with the buffer full drops the entry
        pipe(1, 1, 5'd12, 2'd0, 32'h0000_0012, 32'd0, 3'd0, 2'd0, 32'h0000_5000);
        md(1, 5'd13, 32'h0000_00AB, 32'h0000_0400);
        step();
        expect_wr("rf_pipe", 5'd12, 32'h0000_0012, 32'h0000_5000);
        idle();
        md(1, 5'd13, 32'h0000_00CD, 32'h0000_0404);
        reset = 1'b1;
        #1;
        check("rf_rst_we", {31'd0, grf_we}, 32'd0);
        check("rf_rst_rdy", {31'd0, md_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        expect_idle("rf_after");
        check("rf_after_rdy", {31'd0, md_ready}, 32'd1);
        step();
        md(0, 5'd0, 32'd0, 32'd0);
        #1;
        expect_wr("rf_reoffer", 5'd13, 32'h0000_00CD, 32'h0000_0404);
        step();
        expect_idle("rf_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
